// File: rtl/nand_path_pkg.sv
// Shared types and constants for the NAND path tester.
// Imported by nand_chain and nand_path_tester.
package nand_path_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int          VEC_W        = 16;
  localparam logic [15:0] ERR_MAX      = 16'hFFFF;
  localparam int          DRAIN_CYCLES = 2;

endpackage

// File: rtl/nand2x1_sc.sv
// Two-input NAND standard cell model.
// Purely combinational; ports follow the cell library naming.
module nand2x1_sc (
  input  logic A,
  input  logic B,
  output logic Y
);

  assign Y = ~(A & B);

endmodule

// File: rtl/nand_chain.sv
// One lane of DEPTH NAND cells: first stage NAND(a,1),
// later stages NAND(x,x) with both pins on the previous output.
module nand_chain #(
  parameter int DEPTH = 2
) (
  input  logic a_i,
  output logic y_o
);

  logic [DEPTH-1:0] s;

  nand2x1_sc u_st0 (
    .A(a_i),
    .B(1'b1),
    .Y(s[0])
  );

  for (genvar g = 1; g < DEPTH; g++) begin : g_st
    nand2x1_sc u_st (
      .A(s[g-1]),
      .B(s[g-1]),
      .Y(s[g])
    );
  end

  assign y_o = s[DEPTH-1];

endmodule

// File: rtl/nand_path_tester.sv
// Launches counter patterns into WIDTH NAND chains and checks them.
// Optional NAND_PATH_FAULT_INJ_EN adds inj_mask XORed into the capture.
module nand_path_tester
  import nand_path_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_vectors,
`ifdef NAND_PATH_FAULT_INJ_EN
  input  logic [WIDTH-1:0] inj_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] fail_mask
);

  localparam logic PAR = (DEPTH % 2) == 1;

  state_e           state_q, state_d;
  logic [15:0]      vec_cnt_q, vec_cnt_d;
  logic [15:0]      nvec_q, nvec_d;
  logic [WIDTH-1:0] launch_q, launch_d;
  logic             lval_q, lval_d;
  logic [WIDTH-1:0] cap_q, exp_q;
  logic             cval_q;
  logic [15:0]      err_count_q, err_count_d;
  logic [WIDTH-1:0] fail_q, fail_d;
  logic [1:0]       drain_q, drain_d;
  logic [WIDTH-1:0] pat, chain_y, cap_d, mism;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign pat[g] = vec_cnt_q[g % VEC_W];
    nand_chain #(.DEPTH(DEPTH)) u_chain (
      .a_i(launch_q[g]),
      .y_o(chain_y[g])
    );
  end

`ifdef NAND_PATH_FAULT_INJ_EN
  assign cap_d = chain_y ^ inj_mask;
`else
  assign cap_d = chain_y;
`endif

  assign mism = cap_q ^ exp_q;

  // Next-state: FSM sequencing, launch, and compare accumulation.
  always_comb begin
    state_d     = state_q;
    vec_cnt_d   = vec_cnt_q;
    nvec_d      = nvec_q;
    launch_d    = launch_q;
    lval_d      = 1'b0;
    err_count_d = err_count_q;
    fail_d      = fail_q;
    drain_d     = drain_q;
    if (cval_q) begin
      fail_d = fail_q | mism;
      if ((|mism) && (err_count_q != ERR_MAX))
        err_count_d = err_count_q + 16'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_cnt_d   = '0;
          err_count_d = '0;
          fail_d      = '0;
          nvec_d      = num_vectors;
          state_d     = (num_vectors == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        launch_d  = pat;
        lval_d    = 1'b1;
        vec_cnt_d = vec_cnt_q + 16'd1;
        if (vec_cnt_q == nvec_q - 16'd1) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(DRAIN_CYCLES - 1))
          state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_cnt_q   <= '0;
      nvec_q      <= '0;
      launch_q    <= '0;
      lval_q      <= 1'b0;
      cap_q       <= '0;
      exp_q       <= '0;
      cval_q      <= 1'b0;
      err_count_q <= '0;
      fail_q      <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      vec_cnt_q   <= vec_cnt_d;
      nvec_q      <= nvec_d;
      launch_q    <= launch_d;
      lval_q      <= lval_d;
      cap_q       <= cap_d;
      exp_q       <= launch_q ^ {WIDTH{PAR}};
      cval_q      <= lval_q;
      err_count_q <= err_count_d;
      fail_q      <= fail_d;
      drain_q     <= drain_d;
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign err_count = err_count_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_nand_path_tester.sv
// Table-driven bench with a run scoreboard for nand_path_tester.
// Covers a WIDTH=4/DEPTH=2 instance and a WIDTH=1/DEPTH=3 instance.
module tb_nand_path_tester;

  logic        clk = 1'b0;
  logic        rst, start, start3;
  logic [15:0] nv, nv3;
  logic        busy, done, busy3, done3;
  logic [15:0] errc, err3;
  logic [3:0]  failm, inj;
  logic [0:0]  fail3, inj3;

  int ncmp = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  nand_path_tester #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_vectors(nv),
`ifdef NAND_PATH_FAULT_INJ_EN
    .inj_mask(inj),
`endif
    .busy(busy),
    .done(done),
    .err_count(errc),
    .fail_mask(failm)
  );

  nand_path_tester #(.WIDTH(1), .DEPTH(3)) dut3 (
    .clk(clk),
    .rst(rst),
    .start(start3),
    .num_vectors(nv3),
`ifdef NAND_PATH_FAULT_INJ_EN
    .inj_mask(inj3),
`endif
    .busy(busy3),
    .done(done3),
    .err_count(err3),
    .fail_mask(fail3)
  );

  typedef struct {
    logic [15:0] err;
    logic [31:0] fail;
    int          bcyc;
  } exp_t;

  typedef struct {
    int       n;
    bit       frc;
    logic [3:0] im;
    bit       sat;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Reference: counter pattern, parity-based expected value,
  // captured value either true chain output or forced zero.
  function automatic exp_t model(input int w, input int d, input int n,
                                 input bit frc, input logic [31:0] im,
                                 input logic [15:0] init);
    exp_t r;
    logic [31:0] pv, ex, cp, mm;
    logic [15:0] v16;
    r.err  = init;
    r.fail = '0;
    for (int v = 0; v < n; v++) begin
      v16 = 16'(v);
      pv  = '0;
      for (int i = 0; i < w; i++) pv[i] = v16[i % 16];
      ex = (d % 2 == 1) ? ~pv : pv;
      cp = (frc ? 32'd0 : ex) ^ im;
      mm = (cp ^ ex) & ((32'd1 << w) - 32'd1);
      r.fail |= mm;
      if (mm != 0 && r.err != 16'hFFFF) r.err = r.err + 16'd1;
    end
    r.bcyc = (n > 0) ? n + 2 : 0;
    return r;
  endfunction

  task automatic run_main(input vec_t t);
    exp_t e;
    int   bc, cyc;
    sb.push_back(model(4, 2, t.n, t.frc, {28'd0, t.im},
                       t.sat ? 16'hFFFD : 16'h0000));
    if (t.frc) force dut.cap_q = '0;
    @(negedge clk);
    start = 1'b1;
    nv    = 16'(t.n);
    inj   = t.im;
    @(negedge clk);
    start = 1'b0;
    bc  = 0;
    cyc = 0;
    while (!done && cyc < t.n + 20) begin
      if (t.sat && cyc == 0) force dut.err_count_q = 16'hFFFD;
      if (t.sat && cyc == 1) release dut.err_count_q;
      if (busy) bc++;
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    chk($sformatf("done_seen n=%0d", t.n), {31'd0, done}, 32'd1);
    chk($sformatf("busy_cyc n=%0d", t.n), bc, e.bcyc);
    chk($sformatf("err n=%0d", t.n), {16'd0, errc}, {16'd0, e.err});
    chk($sformatf("fail n=%0d", t.n), {28'd0, failm}, e.fail);
    @(negedge clk);
    chk($sformatf("done_pulse n=%0d", t.n), {31'd0, done}, 32'd0);
    if (t.frc) release dut.cap_q;
    inj = '0;
  endtask

  task automatic run3(input int n, input bit frc);
    exp_t e;
    int   bc, cyc;
    sb.push_back(model(1, 3, n, frc, 32'd0, 16'h0000));
    if (frc) force dut3.cap_q = '0;
    @(negedge clk);
    start3 = 1'b1;
    nv3    = 16'(n);
    @(negedge clk);
    start3 = 1'b0;
    bc  = 0;
    cyc = 0;
    while (!done3 && cyc < n + 20) begin
      start3 = (cyc == 2);
      if (cyc == 2) nv3 = 16'd100;
      if (busy3) bc++;
      @(negedge clk);
      cyc++;
    end
    start3 = 1'b0;
    e = sb.pop_front();
    chk($sformatf("d3_done n=%0d", n), {31'd0, done3}, 32'd1);
    chk($sformatf("d3_busy n=%0d", n), bc, e.bcyc);
    chk($sformatf("d3_err n=%0d", n), {16'd0, err3}, {16'd0, e.err});
    chk($sformatf("d3_fail n=%0d", n), {31'd0, fail3}, e.fail);
    @(negedge clk);
    chk("d3_after", {31'd0, busy3 | done3}, 32'd0);
    if (frc) release dut3.cap_q;
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    nv = '0; nv3 = '0; inj = '0; inj3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {16'd0, errc}, 32'd0);
    chk("rst_fail", {28'd0, failm}, 32'd0);
    rst = 1'b0;

    tbl.push_back('{n: 10, frc: 1'b0, im: 4'h0, sat: 1'b0});
    tbl.push_back('{n: 0,  frc: 1'b0, im: 4'h0, sat: 1'b0});
    tbl.push_back('{n: 5,  frc: 1'b1, im: 4'h0, sat: 1'b0});
    tbl.push_back('{n: 1,  frc: 1'b1, im: 4'h0, sat: 1'b0});
    tbl.push_back('{n: 17, frc: 1'b1, im: 4'h0, sat: 1'b0});
`ifdef NAND_PATH_FAULT_INJ_EN
    tbl.push_back('{n: 5, frc: 1'b0, im: 4'b0100, sat: 1'b0});
    tbl.push_back('{n: 65535, frc: 1'b0, im: 4'b0001, sat: 1'b0});
`endif
    tbl.push_back('{n: 3,  frc: 1'b0, im: 4'h0, sat: 1'b0});
    tbl.push_back('{n: 20, frc: 1'b1, im: 4'h0, sat: 1'b1});
    foreach (tbl[k]) run_main(tbl[k]);

    repeat (5) @(negedge clk);
    chk("idle_hold_err", {16'd0, errc}, 32'h0000FFFF);

    // Abort a run with reset three cycles in.
    start = 1'b1; nv = 16'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_err", {16'd0, errc}, 32'd0);
    chk("mid_fail", {28'd0, failm}, 32'd0);
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy) dn++;
      @(negedge clk);
    end
    chk("mid_no_done", dn, 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; nv = 16'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    chk("rst_prio_done", {31'd0, done}, 32'd0);

    run3(4, 1'b0);
    run3(4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
